// File: rtl/odo_sbox_lanes_if.sv
// -----------------------------------------------------------------------------
// odo_sbox_lanes_if
// Bundles the table-load, lookup-request and lookup-result channels of the
// Odo multi-lane S-box engine.
//   cfg_*      : table load stream (cfg_start, cfg_valid, cfg_data -> cfg_ready,
//                load_done, table_ok)
//   in_*       : lookup request (in_valid, in_inv, in_data -> in_ready)
//   out_*      : lookup result (out_valid, out_data, out_err <- out_ready)
// The master modport belongs to the agent that drives the engine; the slave
// modport belongs to the engine itself.
// -----------------------------------------------------------------------------
interface odo_sbox_lanes_if #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
);
  logic                     cfg_start;
  logic                     cfg_valid;
  logic [WIDTH-1:0]         cfg_data;
  logic                     cfg_ready;
  logic                     load_done;
  logic                     table_ok;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_inv;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   out_data;
  logic                     out_err;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_inv, in_data, out_ready,
    input  cfg_ready, load_done, table_ok, in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_inv, in_data, out_ready,
    output cfg_ready, load_done, table_ok, in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/odo_sbox_lanes.sv
// -----------------------------------------------------------------------------
// odo_sbox_lanes
// Runtime-loadable S-box lookup engine with LANES parallel lookups per cycle.
// A 2**WIDTH-entry table is streamed in after cfg_start; the engine builds a
// forward and an inverse copy per lane and checks that the table is a
// permutation. In RUN, each accepted request returns LANES forward or inverse
// lookups one cycle later under a valid/ready handshake.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : odo_sbox_lanes_if.slave (cfg / in / out channels)
// -----------------------------------------------------------------------------
module odo_sbox_lanes #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  odo_sbox_lanes_if.slave       bus
);

  localparam int DEPTH = 1 << WIDTH;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                   state_q;
  logic [WIDTH-1:0]         cnt_q;
  logic [DEPTH-1:0]         seen_q;
  logic                     dup_q;
  logic                     cfg_ready_q;
  logic                     load_done_q;
  logic                     table_ok_q;
  logic                     out_valid_q;
  logic                     out_err_q;
  logic [LANES*WIDTH-1:0]   out_data_q;

  // One table copy per lane so every lane can read in the same cycle.
  logic [WIDTH-1:0]         fwd_mem [LANES][DEPTH];
  logic [WIDTH-1:0]         inv_mem [LANES][DEPTH];

  logic                     wr_s;
  logic                     last_s;
  logic                     dup_hit_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     err_d;
  logic [LANES*WIDTH-1:0]   lut_d;

  // cfg_start takes priority: an entry presented with it is discarded.
  assign wr_s       = (state_q == LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign last_s     = wr_s && (cnt_q == CNT_LAST);
  assign dup_hit_s  = seen_q[bus.cfg_data];
  assign in_ready_s = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.load_done = load_done_q;
  assign bus.table_ok  = table_ok_q;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  // Lane-wise table read for the current request; an erroring request yields zeros.
  always_comb begin
    err_d = bus.in_inv && !table_ok_q;
    lut_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (err_d) begin
        lut_d[k*WIDTH +: WIDTH] = '0;
      end else if (bus.in_inv) begin
        lut_d[k*WIDTH +: WIDTH] = inv_mem[k][bus.in_data[k*WIDTH +: WIDTH]];
      end else begin
        lut_d[k*WIDTH +: WIDTH] = fwd_mem[k][bus.in_data[k*WIDTH +: WIDTH]];
      end
    end
  end

  // Table RAM writes, broadcast to every lane copy; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_s) begin
      for (int k = 0; k < LANES; k++) begin
        fwd_mem[k][cnt_q]        <= bus.cfg_data;
        inv_mem[k][bus.cfg_data] <= cnt_q;
      end
    end
  end

  // Control FSM, load bookkeeping and registered lookup result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seen_q      <= '0;
      dup_q       <= 1'b0;
      cfg_ready_q <= 1'b0;
      load_done_q <= 1'b0;
      table_ok_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      load_done_q <= 1'b0;
      if (bus.cfg_start) begin
        // Same entry action from every state: (re)start the load from scratch.
        state_q     <= LOAD;
        cfg_ready_q <= 1'b1;
        cnt_q       <= '0;
        seen_q      <= '0;
        dup_q       <= 1'b0;
        table_ok_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cfg_ready_q <= 1'b0;
          end
          LOAD: begin
            if (bus.cfg_valid) begin
              seen_q[bus.cfg_data] <= 1'b1;
              if (dup_hit_s) begin
                dup_q <= 1'b1;
              end
              cnt_q <= cnt_q + CNT_ONE;
              if (last_s) begin
                // Fold in the last entry's own duplicate check.
                state_q     <= RUN;
                cfg_ready_q <= 1'b0;
                load_done_q <= 1'b1;
                table_ok_q  <= !(dup_q || dup_hit_s);
              end
            end
          end
          RUN: begin
            cfg_ready_q <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b0;
          end
        endcase
      end

      // Result register: load on accept, hold while stalled, drop on consume.
      if (accept_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lut_d;
        out_err_q   <= err_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_odo_sbox_lanes.sv
module tb_odo_sbox_lanes;
  localparam int W  = 6;
  localparam int L  = 4;
  localparam int D  = 64;
  localparam int DW = W * L;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  odo_sbox_lanes_if #(.WIDTH(W), .LANES(L)) bus ();
  odo_sbox_lanes #(.WIDTH(W), .LANES(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: the table as loaded, its inverse, and the permutation verdict.
  logic [W-1:0] tbl_v [D];
  logic [W-1:0] fwd_m [D];
  logic [W-1:0] inv_m [D];
  bit           ok_m;
  logic [DW:0]  exp_q [$];   // {err, data}

  typedef struct {
    logic          inv;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          err;
  } vec_t;
  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_perm();
    int hits [D];
    for (int v = 0; v < D; v++) hits[v] = 0;
    for (int i = 0; i < D; i++) hits[tbl_v[i]]++;
    for (int v = 0; v < D; v++) if (hits[v] != 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW:0] model_lookup(input logic inv, input logic [DW-1:0] din);
    logic [DW-1:0] r;
    logic [W-1:0]  v;
    r = '0;
    if (inv && !ok_m) return {1'b1, {DW{1'b0}}};
    for (int k = 0; k < L; k++) begin
      v = din[k*W +: W];
      r[k*W +: W] = inv ? inv_m[v] : fwd_m[v];
    end
    return {1'b0, r};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_cfg_ready"}, bus.cfg_ready, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
    chk({tag, "_table_ok"},  bus.table_ok,  0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data,  0);
    chk({tag, "_out_err"},   bus.out_err,   0);
    chk({tag, "_in_ready"},  bus.in_ready,  0);
  endtask

  // Streams tbl_v into the engine, one entry per cycle, and checks completion.
  task automatic load_table(input bit do_start);
    if (do_start) begin
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      ok_m = 1'b0;
    end
    for (int i = 0; i < D; i++) begin
      chk("load_cfg_ready", bus.cfg_ready, 1);
      chk("load_in_ready", bus.in_ready, 0);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = tbl_v[i];
      step();
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < D; i++) fwd_m[i] = tbl_v[i];
    for (int i = 0; i < D; i++) inv_m[tbl_v[i]] = W'(i);
    ok_m = is_perm();
    chk("load_done_pulse", bus.load_done, 1);
    chk("load_table_ok", bus.table_ok, ok_m);
    chk("load_cfg_ready_off", bus.cfg_ready, 0);
    step();
    chk("load_done_clear", bus.load_done, 0);
  endtask

  task automatic do_lookup(input string tag, input logic inv, input logic [DW-1:0] din,
                           input logic [DW-1:0] dout, input logic err);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_inv    = inv;
    bus.in_data   = din;
    #1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    chk({tag, "_out_data"}, bus.out_data, dout);
    chk({tag, "_out_err"}, bus.out_err, err);
    step();
    chk({tag, "_out_valid_clear"}, bus.out_valid, 0);
  endtask

  // Random requests with random back-pressure, scored against the model.
  task automatic rand_traffic(input int n);
    bit exp_rdy;
    for (int c = 0; c < n; c++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_inv    = ($urandom_range(0, 1) == 1);
      bus.in_data   = DW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (exp_q.size() == 0) || bus.out_ready;
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rnd_result", {bus.out_err, bus.out_data}, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.in_valid && exp_rdy) exp_q.push_back(model_lookup(bus.in_inv, bus.in_data));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    if (exp_q.size() != 0) chk("rnd_drain", {bus.out_err, bus.out_data}, exp_q[0]);
    exp_q.delete();
    step();
    chk("rnd_drained", bus.out_valid, 0);
  endtask

  task automatic shuffle_table();
    logic [W-1:0] t;
    int j;
    for (int i = 0; i < D; i++) tbl_v[i] = W'(i);
    for (int i = D - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = tbl_v[i];
      tbl_v[i] = tbl_v[j];
      tbl_v[j] = t;
    end
  endtask

  initial begin
    // Vectors for f(i) = (5i+3) mod 64; lane 0 in the low bits.
    vecs[0] = '{1'b0, {6'h3F, 6'h02, 6'h01, 6'h00}, {6'h3E, 6'h0D, 6'h08, 6'h03}, 1'b0};
    vecs[1] = '{1'b1, {6'h0D, 6'h3E, 6'h03, 6'h08}, {6'h02, 6'h3F, 6'h00, 6'h01}, 1'b0};
    vecs[2] = '{1'b0, {6'h10, 6'h20, 6'h30, 6'h3C}, {6'h13, 6'h23, 6'h33, 6'h2F}, 1'b0};
    vecs[3] = '{1'b1, {6'h13, 6'h23, 6'h33, 6'h2F}, {6'h10, 6'h20, 6'h30, 6'h3C}, 1'b0};
    vecs[4] = '{1'b0, {6'h3F, 6'h3E, 6'h3D, 6'h3C}, {6'h3E, 6'h39, 6'h34, 6'h2F}, 1'b0};
    vecs[5] = '{1'b1, {6'h03, 6'h03, 6'h3E, 6'h3E}, {6'h00, 6'h00, 6'h3F, 6'h3F}, 1'b0};

    rst_n = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    ok_m = 1'b0;
    repeat (2) step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();
    chk("pre_load_in_ready", bus.in_ready, 0);
    chk("pre_load_cfg_ready", bus.cfg_ready, 0);

    // Test-plan table and table-driven vectors.
    for (int i = 0; i < D; i++) tbl_v[i] = W'((5 * i + 3) % 64);
    load_table(1'b1);
    chk("affine_table_ok", bus.table_ok, 1);
    for (int v = 0; v < 6; v++) do_lookup($sformatf("vec%0d", v), vecs[v].inv, vecs[v].din, vecs[v].dout, vecs[v].err);

    // Stall: pending result held for 3 cycles, next accept only with the consume.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inv    = 1'b0;
    bus.in_data   = {6'h3F, 6'h02, 6'h01, 6'h00};
    #1;
    chk("stall_first_accept", bus.in_ready, 1);
    step();
    bus.in_data = {6'h10, 6'h20, 6'h30, 6'h3C};
    for (int c = 0; c < 3; c++) begin
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_data", bus.out_data, {6'h3E, 6'h0D, 6'h08, 6'h03});
      chk("stall_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("stall_next_valid", bus.out_valid, 1);
    chk("stall_next_data", bus.out_data, {6'h13, 6'h23, 6'h33, 6'h2F});
    step();
    chk("stall_drained", bus.out_valid, 0);

    // Duplicate entry: entry 10 repeats entry 9 (0x30).
    tbl_v[10] = tbl_v[9];
    load_table(1'b1);
    chk("dup_table_ok", bus.table_ok, 0);
    do_lookup("dup_inv", 1'b1, {6'h0D, 6'h3E, 6'h03, 6'h08}, {DW{1'b0}}, 1'b1);
    do_lookup("dup_fwd", 1'b0, {6'h00, 6'h0B, 6'h0A, 6'h09}, {6'h03, 6'h3A, 6'h30, 6'h30}, 1'b0);

    // cfg_start on the same edge as an accepted lookup: old table answers.
    bus.in_valid  = 1'b1;
    bus.in_inv    = 1'b0;
    bus.in_data   = {6'h0A, 6'h02, 6'h01, 6'h00};
    bus.cfg_start = 1'b1;
    #1;
    chk("restart_accept", bus.in_ready, 1);
    step();
    bus.cfg_start = 1'b0;
    ok_m = 1'b0;
    bus.in_data = DW'($urandom);
    chk("restart_out_valid", bus.out_valid, 1);
    chk("restart_out_data", bus.out_data, {6'h30, 6'h0D, 6'h08, 6'h03});
    chk("restart_out_err", bus.out_err, 0);
    chk("restart_cfg_ready", bus.cfg_ready, 1);
    chk("restart_table_ok", bus.table_ok, 0);
    for (int i = 0; i < D; i++) tbl_v[i] = W'((7 * i + 1) % 64);
    load_table(1'b0);
    rand_traffic(150);

    // Reset after 20 load entries, stray cfg_valid, then a full reload.
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = W'($urandom);
      step();
    end
    bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ok_m = 1'b0;
    chk_reset("midload_rst");
    for (int c = 0; c < 3; c++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = W'($urandom);
      step();
      chk("idle_cfg_ready", bus.cfg_ready, 0);
      chk("idle_load_done", bus.load_done, 0);
      chk("idle_in_ready", bus.in_ready, 0);
    end
    bus.cfg_valid = 1'b0;
    shuffle_table();
    load_table(1'b1);
    chk("reload_table_ok", bus.table_ok, 1);
    rand_traffic(200);

    // Arbitrary table (typically non-permutation): inverse lookups must error.
    for (int i = 0; i < D; i++) tbl_v[i] = W'($urandom);
    load_table(1'b1);
    rand_traffic(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odo_sbox_lanes.md
Name: odo_sbox_lanes

Overview:
Parametrised, runtime-loadable, multi-lane S-box lookup engine for the Odo hash core; the successor to the fixed 6-bit ROM S-boxes.
- Table (one 2**WIDTH-entry permutation) streamed in at epoch change.
- Replicated per lane: LANES parallel forward or inverse lookups per cycle.
- Valid/ready handshake on input and output; permutation check on load.

Parameters:
WIDTH, 6, S-box input/output width in bits; DEPTH = 2**WIDTH entries (derived, not a parameter).
LANES, 4, independent lookups per transaction.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cfg_start  input  1  begin/restart table load
cfg_valid  input  1  table entry present on cfg_data
cfg_data  input  WIDTH  next table entry; address is implicit, counting 0..DEPTH-1
cfg_ready  output  1  engine accepts table entries (state LOAD)
load_done  output  1  one-cycle pulse when the load completes
table_ok  output  1  loaded table is a permutation (valid until next cfg_start or reset)
in_valid  input  1  lookup request
in_ready  output  1  lookup accepted when in_valid&&in_ready
in_inv  input  1  0 = forward table, 1 = inverse table
in_data  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
out_valid  output  1  result present
out_ready  input  1  result consumed when out_valid&&out_ready
out_data  output  LANES*WIDTH  lane-wise lookup result
out_err  output  1  result invalid (inverse lookup with table_ok=0)

Behaviour:
- Clock/reset: one clock clk; reset rst_n is synchronous, active-low.
- Reset state:
  - state IDLE.
  - cfg_ready=0, load_done=0, table_ok=0, out_valid=0, out_data=0, out_err=0, in_ready=0.
  - Table RAMs are not cleared.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD on cfg_start.
  - LOAD -> RUN on acceptance of the DEPTH-th entry.
  - RUN -> LOAD on cfg_start.
  - cfg_start in LOAD restarts the load.
- Entering LOAD:
  - Write counter = 0; seen bitmap (DEPTH bits) cleared; dup flag cleared; table_ok = 0.
- LOAD, cfg_valid && !cfg_start:
  - fwd[cnt] <= cfg_data; inv[cfg_data] <= cnt.
  - If seen[cfg_data] is already set, dup <= 1; then seen[cfg_data] <= 1; cnt++.
  - Writes go to all LANES copies.
- cfg_start and cfg_valid in the same cycle: restart wins, entry discarded.
- Load completion (last entry accepted):
  - Next cycle: state = RUN, load_done = 1 for exactly one cycle.
  - table_ok = !dup, with the last entry's duplicate check included.
- cfg_ready = (state == LOAD), registered from state.
- in_ready = (state == RUN) && (!out_valid || out_ready).
- Lookup:
  - Latency 1: on an accept edge, each lane's out_data <= (in_inv ? inv : fwd)[lane in].
  - out_err <= in_inv && !table_ok; out_valid <= 1.
  - When out_err is set, out_data <= 0 (all lanes).
- Output holding:
  - Output held stable while out_valid && !out_ready.
  - out_valid clears on consume with no new accept.
  - Back-to-back accepts give one result per cycle when out_ready = 1.
- Lookup accepted on the same edge as cfg_start: result is read from the old table, since the first write occurs at the earliest one cycle later.
- Pending output during LOAD: retained until consumed; in_ready = 0 throughout LOAD.
- Reset mid-load: IDLE, table_ok = 0; a new cfg_start and full reload are required.
- Before the first completed load: in_ready = 0.

Test Plan:
- Load f(i) = (5i+3) mod 64 (64 entries, one per cycle): load_done pulses one cycle after the 64th accept, table_ok = 1. Then forward lanes {00,01,02,3F} -> out_data {03,08,0D,3E} one cycle after accept, out_err = 0.
- Same table, in_inv = 1, lanes {08,03,3E,0D} -> {01,00,3F,02}.
- Load with entry 10 = entry 9 (duplicate): table_ok = 0. Inverse lookup -> out_err = 1, out_data = 0. Forward lookup of lane 10 -> the duplicated value, out_err = 0.
- out_ready held low 3 cycles with a pending result: out_data/out_valid stable, in_ready = 0. Next accept only after the consume.
- cfg_start asserted on the same edge as an accepted lookup: result reflects the old table; in_ready = 0 for the whole reload; cfg_ready = 1 the next cycle.
- rst_n low for one cycle after 20 load entries: all outputs at reset values. cfg_valid is ignored until cfg_start; a subsequent full load gives table_ok = 1.
